// File: rtl/otf_pkg.sv
// Shared definitions for the radix-4 digit bus: digit type, digit codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: digit_t (3-bit signed digit), RADIX, D_M2..D_P2 digit codes,
// cLog2() for pointer sizing, state_e encoder FSM states.
package otf_pkg;

    localparam int RADIX = 4;

    typedef logic signed [2:0] digit_t;

    localparam digit_t D_M2 = 3'sb110;
    localparam digit_t D_M1 = 3'sb111;
    localparam digit_t D_0  = 3'sb000;
    localparam digit_t D_P1 = 3'sb001;
    localparam digit_t D_P2 = 3'sb010;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Ceiling log2, never less than 1 so a single-digit word still gets a pointer bit.
    function automatic int cLog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/booth4_digit.sv
// Radix-4 minimally redundant recoder: 3-bit group {hi,mid,lo} -> digit -2*hi+mid+lo.
// Latency: combinational.
// Backpressure: none (pure function).
//
// Ports: grp (in, 3) bit group; q (out, 3) signed digit; q_abs (out, 3) magnitude.
module booth4_digit
    import otf_pkg::*;
(
    input  logic [2:0] grp,
    output digit_t     q,
    output logic [2:0] q_abs
);

    always_comb begin
        q = D_0;
        case (grp)
            3'b000, 3'b111: q = D_0;
            3'b001, 3'b010: q = D_P1;
            3'b011:         q = D_P2;
            3'b100:         q = D_M2;
            3'b101, 3'b110: q = D_M1;
            default:        q = D_0;
        endcase
    end

    always_comb begin
        q_abs = 3'b000;
        case (grp)
            3'b001, 3'b010, 3'b101, 3'b110: q_abs = 3'b001;
            3'b011, 3'b100:                 q_abs = 3'b010;
            default:                        q_abs = 3'b000;
        endcase
    end

endmodule

// File: rtl/radix4_digit_encoder.sv
// Serial radix-4 signed-digit generator: emits a WL-bit word MSB-first as N digits in -2..+2.
// Latency: first digit valid the cycle after an accepted start; one digit per accepted cycle.
// Backpressure: out_ready low holds q/q_abs/pointer; CE low freezes everything.
//
// Ports: CLK/RST (sync, active-high), CE, start/din/ready (load side),
// valid/out_ready/q/q_abs/pointer (digit bus), done (end-of-word pulse), chk_err.
// Optional build macro RADIX4_ENC_SELFCHECK_EN: accumulates the emitted digits and
// flags chk_err if they do not reconstruct the loaded word; otherwise chk_err is 0.
module radix4_digit_encoder
    import otf_pkg::*;
#(
    parameter int N          = 12,
    parameter int WL         = 2 * N,
    parameter int RADIX      = 4,
    parameter int addpointer = cLog2(N)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic                  start,
    input  logic [WL-1:0]         din,
    output logic                  ready,
    output logic                  valid,
    input  logic                  out_ready,
    output logic [2:0]            q,
    output logic [2:0]            q_abs,
    output logic [addpointer-1:0] pointer,
    output logic                  done,
    output logic                  chk_err
);

    // Bits consumed per digit; only radix 4 is meaningful for the 3-bit recoder.
    localparam int SH = $clog2(RADIX);

    state_e                state_q, state_d;
    logic [WL-1:0]         shreg_q, shreg_d;
    logic [addpointer-1:0] pointer_q, pointer_d;
    logic [2:0]            q_q, q_d;
    logic [2:0]            q_abs_q, q_abs_d;
    logic                  done_q, done_d;

    logic                  load;
    logic                  accept;
    logic                  last;
    logic [2:0]            nxt_grp;
    digit_t                nxt_q;
    logic [2:0]            nxt_q_abs;

    assign load   = (state_q == IDLE) && start && CE;
    assign accept = (state_q == RUN) && out_ready && CE;
    assign last   = (pointer_q == addpointer'(N - 1));

    // The digit shown next is the top group of the register after this cycle's
    // update. After an accept those are bits [WL-3 -: 3] of the current register;
    // the zeros shifted in supply b[-1]=0 for the final digit.
    assign nxt_grp = load ? din[WL-1 -: 3] : shreg_q[WL-3 -: 3];

    booth4_digit u_booth (
        .grp   (nxt_grp),
        .q     (nxt_q),
        .q_abs (nxt_q_abs)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        pointer_d = pointer_q;
        q_d       = q_q;
        q_abs_d   = q_abs_q;
        done_d    = done_q;
        if (CE) begin
            done_d = 1'b0;
        end
        if (load) begin
            state_d   = RUN;
            shreg_d   = din;
            pointer_d = '0;
            q_d       = nxt_q;
            q_abs_d   = nxt_q_abs;
        end else if (accept) begin
            shreg_d = shreg_q << SH;
            if (last) begin
                state_d   = IDLE;
                pointer_d = '0;
                q_d       = 3'b000;
                q_abs_d   = 3'b000;
                done_d    = 1'b1;
            end else begin
                pointer_d = pointer_q + addpointer'(1);
                q_d       = nxt_q;
                q_abs_d   = nxt_q_abs;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            pointer_q <= '0;
            q_q       <= 3'b000;
            q_abs_q   <= 3'b000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            pointer_q <= pointer_d;
            q_q       <= q_d;
            q_abs_q   <= q_abs_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign valid   = (state_q == RUN);
    assign q       = q_q;
    assign q_abs   = q_abs_q;
    assign pointer = pointer_q;
    assign done    = done_q;

`ifdef RADIX4_ENC_SELFCHECK_EN
    // acc tracks sum d_k * 4^(N-1-k) of the digits accepted so far; one extra bit
    // of headroom covers the redundant range of the digit set.
    logic [WL:0]   acc_q, acc_d;
    logic [WL:0]   acc_nxt;
    logic [WL-1:0] din_q, din_d;
    logic          chk_err_q, chk_err_d;

    assign acc_nxt = (acc_q << SH) + {{(WL-2){q_q[2]}}, q_q};

    always_comb begin
        acc_d     = acc_q;
        din_d     = din_q;
        chk_err_d = chk_err_q;
        if (load) begin
            acc_d     = '0;
            din_d     = din;
            chk_err_d = 1'b0;
        end else if (accept) begin
            acc_d = acc_nxt;
            if (last) begin
                chk_err_d = (acc_nxt != {din_q[WL-1], din_q});
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q     <= '0;
            din_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            din_q     <= din_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
